// File: rtl/mixcolumns_serial.sv
// mixcolumns_serial
// AES MixColumns round stage, one 32-bit column per clock through a single
// combinational column multiplier. A full 128-bit state takes four cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle request; state_in/inverse/bypass sampled with it
//   state_in   128-bit input state, column c at [32c +: 32], row r at +8r
//   inverse    1 = InvMixColumns, 0 = MixColumns
//   bypass     1 = pass columns through unchanged (overrides inverse)
//   state_out  128-bit result, filled column 0..3; unfinished columns read 0
//   done       level, high from completion until the next accepted start
//   busy       high while columns are being processed
module mixcolumns_serial (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state_in,
  input  logic         inverse,
  input  logic         bypass,
  output logic [127:0] state_out,
  output logic         done,
  output logic         busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     col_q, col_d;
  logic [127:0]   cap_q, cap_d;
  logic           inv_q, inv_d;
  logic           byp_q, byp_d;
  logic [127:0]   out_q, out_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  logic [31:0]    cur_col_s;
  logic [31:0]    res_col_s;

  // GF(2^8) multiply by 2 modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward column map, coefficients 02/03/01/01 rotating per row
  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    a0 = c[7:0];   a1 = c[15:8];  a2 = c[23:16]; a3 = c[31:24];
    d0 = xtime(a0); d1 = xtime(a1); d2 = xtime(a2); d3 = xtime(a3);
    mix_fwd[7:0]   = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
    mix_fwd[15:8]  = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
    mix_fwd[23:16] = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
    mix_fwd[31:24] = (d0 ^ a0) ^ a1 ^ a2 ^ d3;
  endfunction

  // Inverse column map, coefficients 0e/0b/0d/09 rotating per row.
  // Each byte is expanded once into x2/x4/x8 and the four products are
  // assembled from those: 09=8+1, 0b=8+2+1, 0d=8+4+1, 0e=8+4+2.
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[8*i +: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    mix_inv[7:0]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    mix_inv[15:8]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    mix_inv[23:16] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    mix_inv[31:24] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
  endfunction

  // Select the captured column addressed by the column counter
  always_comb begin
    cur_col_s = 32'h0000_0000;
    case (col_q)
      2'd0:    cur_col_s = cap_q[31:0];
      2'd1:    cur_col_s = cap_q[63:32];
      2'd2:    cur_col_s = cap_q[95:64];
      2'd3:    cur_col_s = cap_q[127:96];
      default: cur_col_s = 32'h0000_0000;
    endcase
  end

  // Single column multiplier; bypass takes priority over inverse
  always_comb begin
    res_col_s = cur_col_s;
    if (byp_q) begin
      res_col_s = cur_col_s;
    end else if (inv_q) begin
      res_col_s = mix_inv(cur_col_s);
    end else begin
      res_col_s = mix_fwd(cur_col_s);
    end
  end

  // Next-state and registered-output logic for the IDLE/RUN controller
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cap_d   = cap_q;
    inv_d   = inv_q;
    byp_d   = byp_q;
    out_d   = out_q;
    done_d  = done_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cap_d   = state_in;
          inv_d   = inverse;
          byp_d   = bypass;
          out_d   = 128'h0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          col_d   = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // start is deliberately not looked at here, including the final cycle
        out_d[{col_q, 5'd0} +: 32] = res_col_s;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      cap_q   <= 128'h0;
      inv_q   <= 1'b0;
      byp_q   <= 1'b0;
      out_q   <= 128'h0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cap_q   <= cap_d;
      inv_q   <= inv_d;
      byp_q   <= byp_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign state_out = out_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule
